seq_div16s8s: RTL and testbench

- Sequential signed divider: 16-bit signed dividend by 8-bit signed divisor, producing a 16-bit signed quotient and an 8-bit signed remainder.
- It is the inverse operation of the team's signed 8x8 multipliers. It is used to recover an operand from a product, and for error-analysis datapaths that normalise multiplier outputs.
- Exact arithmetic only: restoring, one quotient bit per cycle.
- Valid/ready handshake on input and output. One operation in flight at a time.

---
 rtl/seq_div16s8s.sv | 130 +++++++++++++
 tb/tb_seq_div16s8s.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_div16s8s.sv
// Sequential restoring signed divider: DW-bit signed dividend / VW-bit signed divisor.
// One quotient bit per cycle, fixed data-independent latency, valid/ready on both sides.
module seq_div16s8s #(
    parameter int DW = 16,
    parameter int VW = 8,
    parameter int CW = $clog2(DW + 1)
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero,
    output logic          overflow
);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    localparam logic [DW-1:0] DVD_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] Q_MAX   = {1'b0, {(DW-1){1'b1}}};

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dvd_raw;
    logic [VW-1:0] dvs_raw;
    logic          sign_q;
    logic          sign_r;
    logic          dz_case;
    logic          ovf_case;
    logic [DW-1:0] q_reg;     // holds |dividend|, shifts out MSBs while quotient bits shift in
    logic [VW-1:0] prem;
    logic [VW-1:0] dvs_abs;

    logic [VW:0]   shifted;
    logic          trial_ok;

    assign shifted  = {prem, q_reg[DW-1]};
    assign trial_ok = shifted >= {1'b0, dvs_abs};

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd_raw   <= '0;
            dvs_raw   <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dz_case   <= 1'b0;
            ovf_case  <= 1'b0;
            q_reg     <= '0;
            prem      <= '0;
            dvs_abs   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_raw  <= dividend;
                        dvs_raw  <= divisor;
                        sign_q   <= dividend[DW-1] ^ divisor[VW-1];
                        sign_r   <= dividend[DW-1];
                        in_ready <= 1'b0;
                        state    <= PREP;
                    end
                end
                PREP: begin
                    // Unsigned DW/VW bits already cover the magnitude of the most negative value.
                    q_reg    <= dvd_raw[DW-1] ? -dvd_raw : dvd_raw;
                    dvs_abs  <= dvs_raw[VW-1] ? -dvs_raw : dvs_raw;
                    dz_case  <= (dvs_raw == '0);
                    ovf_case <= (dvd_raw == DVD_MIN) && (dvs_raw == '1);
                    prem     <= '0;
                    cnt      <= '0;
                    state    <= CALC;
                end
                CALC: begin
                    q_reg <= {q_reg[DW-2:0], trial_ok};
                    prem  <= trial_ok ? VW'(shifted - {1'b0, dvs_abs}) : shifted[VW-1:0];
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(DW - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz_case) begin
                        quotient  <= sign_r ? DVD_MIN : Q_MAX;
                        remainder <= '0;
                        div_zero  <= 1'b1;
                        overflow  <= 1'b0;
                    end else if (ovf_case) begin
                        quotient  <= Q_MAX;
                        remainder <= '0;
                        div_zero  <= 1'b0;
                        overflow  <= 1'b1;
                    end else begin
                        quotient  <= sign_q ? -q_reg : q_reg;
                        remainder <= sign_r ? -prem : prem;
                        div_zero  <= 1'b0;
                        overflow  <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div16s8s.sv
// Directed bench for seq_div16s8s: sign combinations, special cases, backpressure,
// mid-operation reset and a back-to-back run against a truncating reference model.
module tb_seq_div16s8s;

    logic        clock;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    seq_div16s8s dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ref_div(input int a, input int b, output logic [15:0] q, output logic [7:0] r,
                           output logic dz, output logic ov);
        int qi;
        int ri;
        if (b == 0) begin
            q  = (a < 0) ? 16'h8000 : 16'h7FFF;
            r  = 8'h00;
            dz = 1'b1;
            ov = 1'b0;
        end else if (a == -32768 && b == -1) begin
            q  = 16'h7FFF;
            r  = 8'h00;
            dz = 1'b0;
            ov = 1'b1;
        end else begin
            qi = a / b;
            ri = a % b;
            q  = 16'(qi);
            r  = 8'(ri);
            dz = 1'b0;
            ov = 1'b0;
        end
    endtask

    // Issues one operation from a negedge with out_ready high and checks latency and results.
    task automatic do_op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                         input logic [7:0] er, input logic edz, input logic eov, input string tag);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
        end
        check({tag, "_latency"}, 32'(cyc), 32'd18);
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dz"}, 32'(div_zero), 32'(edz));
        check({tag, "_ov"}, 32'(overflow), 32'(eov));
        @(posedge clock);
        @(negedge clock);
        check({tag, "_vdrop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready19"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int cyc;
        int seen;
        int a;
        int b;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        edz;
        logic        eov;
        int dvd_c[6] = '{0, 1, -1, -32768, 32767, -128};
        int dvs_c[6] = '{0, 1, -1, -128, 127, 7};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_flags", 32'({div_zero, overflow}), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        do_op(16'd1000, 8'd7, 16'h008E, 8'h06, 1'b0, 1'b0, "pos_pos");
        do_op(-16'sd1000, 8'd7, 16'hFF72, 8'hFA, 1'b0, 1'b0, "neg_pos");
        do_op(16'd1000, -8'sd7, 16'hFF72, 8'h06, 1'b0, 1'b0, "pos_neg");
        do_op(-16'sd1000, -8'sd7, 16'h008E, 8'hFA, 1'b0, 1'b0, "neg_neg");
        do_op(16'h8000, 8'hFF, 16'h7FFF, 8'h00, 1'b0, 1'b1, "min_m1");
        do_op(16'h8000, 8'h80, 16'h0100, 8'h00, 1'b0, 1'b0, "min_m128");
        do_op(16'h7FFF, 8'h01, 16'h7FFF, 8'h00, 1'b0, 1'b0, "max_1");
        do_op(16'd5, 8'd0, 16'h7FFF, 8'h00, 1'b1, 1'b0, "p5_div0");
        do_op(-16'sd5, 8'd0, 16'h8000, 8'h00, 1'b1, 1'b0, "m5_div0");

        // Backpressure: 12345 / -100 = -123 rem 45, held for 10 cycles.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dividend  = 16'd12345;
        divisor   = -8'sd100;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
        end
        check("bp_latency", 32'(cyc), 32'd18);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            dividend = 16'd77;
            divisor  = 8'd3;
            check("bp_q", 32'(quotient), 32'h0000FF85);
            check("bp_r", 32'(remainder), 32'h0000002D);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clock);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_hold_q", 32'(quotient), 32'h0000FF85);

        // Reset during the eighth CALC iteration.
        in_valid = 1'b1;
        dividend = 16'd30000;
        divisor  = 8'd7;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (8) @(posedge clock);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_q", 32'(quotient), 32'd0);
        check("arst_r", 32'(remainder), 32'd0);
        check("arst_flags", 32'({div_zero, overflow}), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        check("arst_no_result", 32'(seen), 32'd0);
        do_op(16'd100, 8'd3, 16'd33, 8'd1, 1'b0, 1'b0, "after_rst");

        // Back-to-back operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            a = (($urandom_range(0, 2)) == 0) ? dvd_c[$urandom_range(0, 5)]
                                               : $signed(16'($urandom));
            b = (($urandom_range(0, 2)) == 0) ? dvs_c[$urandom_range(0, 5)]
                                               : $signed(8'($urandom));
            ref_div(a, b, eq, er, edz, eov);
            do_op(16'(a), 8'(b), eq, er, edz, eov, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
